// File: rtl/occupancy_monitor_if.sv
// ---------------------------------------------------------------------------
// occupancy_monitor_if
// Bundles the sensor inputs, flag clear and all count/display/alarm outputs
// of occupancy_monitor.
//   Parameters : CNT_W (binary count width), DIGITS (BCD display digits)
//   master     : drives entry_det, exit_det, clear_flags; observes the rest
//   slave      : the monitor itself
//   Signals    : entry_det, exit_det (raw async sensor levels), clear_flags,
//                count, bcd, alarm, full, overflow, underflow, and either
//                seg_all (parallel display) or seg_mux/dig_sel when the
//                DISPLAY_MUX_EN macro is defined.
// ---------------------------------------------------------------------------
interface occupancy_monitor_if #(
   parameter int CNT_W  = 8,
   parameter int DIGITS = 3
);
   logic                  entry_det;
   logic                  exit_det;
   logic                  clear_flags;
   logic [CNT_W-1:0]      count;
   logic [4*DIGITS-1:0]   bcd;
`ifdef DISPLAY_MUX_EN
   logic [6:0]            seg_mux;
   logic [DIGITS-1:0]     dig_sel;
`else
   logic [7*DIGITS-1:0]   seg_all;
`endif
   logic                  alarm;
   logic                  full;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output entry_det, exit_det, clear_flags,
      input  count, bcd,
`ifdef DISPLAY_MUX_EN
      input  seg_mux, dig_sel,
`else
      input  seg_all,
`endif
      input  alarm, full, overflow, underflow
   );

   modport slave (
      input  entry_det, exit_det, clear_flags,
      output count, bcd,
`ifdef DISPLAY_MUX_EN
      output seg_mux, dig_sel,
`else
      output seg_all,
`endif
      output alarm, full, overflow, underflow
   );
endinterface

// File: rtl/occupancy_monitor.sv
// ---------------------------------------------------------------------------
// occupancy_monitor
// Bidirectional room occupancy counter. Each raw sensor is synchronised,
// debounced, and its rising debounced edge becomes a one-cycle event. The
// binary count saturates at CAPACITY; a BCD shadow of the count is kept by
// incremental carry/borrow (no divider) and decoded to 7-segment patterns.
// A registered alarm asserts at ALARM_HI and releases at ALARM_HI-HYST.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : occupancy_monitor_if.slave (sensors, clear_flags, count, bcd,
//            display, alarm, full, overflow, underflow)
//
// Optional feature macro: DISPLAY_MUX_EN
//   undefined : seg_all carries all digits in parallel
//   defined   : seg_mux/dig_sel scan one digit per REFRESH_DIV cycles
// ---------------------------------------------------------------------------
module occupancy_monitor #(
   parameter int CNT_W       = 8,
   parameter int CAPACITY    = 99,
   parameter int ALARM_HI    = 80,
   parameter int HYST        = 5,
   parameter int DIGITS      = 3,
   parameter int DEBOUNCE    = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   occupancy_monitor_if.slave   bus
);

   localparam int RUN_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
   localparam logic [CNT_W-1:0] ALARM_ON  = CNT_W'(ALARM_HI);
   localparam logic [CNT_W-1:0] ALARM_OFF = CNT_W'(ALARM_HI - HYST);
   localparam int BCD_W = 4 * DIGITS;

   // Decimal ripple increment: a digit at 9 wraps to 0 and carries upward.
   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      logic             carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Decimal ripple decrement: a digit at 0 wraps to 9 and borrows upward.
   function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      logic             borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // {g,f,e,d,c,b,a}, active-high; non-decimal codes blank the digit.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b0111111;
         4'd1:    seg_decode = 7'b0000110;
         4'd2:    seg_decode = 7'b1011011;
         4'd3:    seg_decode = 7'b1001111;
         4'd4:    seg_decode = 7'b1100110;
         4'd5:    seg_decode = 7'b1101101;
         4'd6:    seg_decode = 7'b1111101;
         4'd7:    seg_decode = 7'b0000111;
         4'd8:    seg_decode = 7'b1111111;
         4'd9:    seg_decode = 7'b1101111;
         default: seg_decode = 7'b0000000;
      endcase
   endfunction

   // Channel 0 = entry, channel 1 = exit.
   logic [1:0]       raw;
   logic [1:0]       sync_p0;
   logic [1:0]       sync_p1;
   logic [1:0]       deb;
   logic [1:0]       deb_q;
   logic [RUN_W-1:0] run [2];
   logic [1:0]       ev;

   assign raw = {bus.exit_det, bus.entry_det};

   // ---- stage: synchroniser -> debouncer -> edge history ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         deb     <= '0;
         deb_q   <= '0;
         for (int ch = 0; ch < 2; ch++) run[ch] <= '0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         deb_q   <= deb;
         for (int ch = 0; ch < 2; ch++) begin
            if (sync_p1[ch] == deb[ch]) begin
               run[ch] <= '0;
            end else if (run[ch] == RUN_LAST) begin
               deb[ch] <= sync_p1[ch];
               run[ch] <= '0;
            end else begin
               run[ch] <= run[ch] + RUN_W'(1);
            end
         end
      end
   end

   assign ev = deb & ~deb_q;

   logic [CNT_W-1:0] count_r, count_next;
   logic [BCD_W-1:0] bcd_r, bcd_next;
   logic             set_ovf, set_unf;
   logic             alarm_r, overflow_r, underflow_r;

   always_comb begin
      count_next = count_r;
      bcd_next   = bcd_r;
      set_ovf    = 1'b0;
      set_unf    = 1'b0;
      case (ev)
         2'b01: begin
            if (count_r < CAP_C) begin
               count_next = count_r + CNT_W'(1);
               bcd_next   = bcd_inc(bcd_r);
            end else begin
               set_ovf = 1'b1;
            end
         end
         2'b10: begin
            if (count_r != '0) begin
               count_next = count_r - CNT_W'(1);
               bcd_next   = bcd_dec(bcd_r);
            end else begin
               set_unf = 1'b1;
            end
         end
         default: ; // none, or simultaneous entry+exit cancel
      endcase
   end

   // ---- stage: count/BCD/flags update, alarm follows count one cycle later ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r     <= '0;
         bcd_r       <= '0;
         alarm_r     <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         count_r <= count_next;
         bcd_r   <= bcd_next;
         if (count_r >= ALARM_ON)       alarm_r <= 1'b1;
         else if (count_r <= ALARM_OFF) alarm_r <= 1'b0;
         if (set_ovf)               overflow_r <= 1'b1;
         else if (bus.clear_flags)  overflow_r <= 1'b0;
         if (set_unf)               underflow_r <= 1'b1;
         else if (bus.clear_flags)  underflow_r <= 1'b0;
      end
   end

   assign bus.count     = count_r;
   assign bus.bcd       = bcd_r;
   assign bus.alarm     = alarm_r;
   assign bus.full      = (count_r == CAP_C);
   assign bus.overflow  = overflow_r;
   assign bus.underflow = underflow_r;

`ifdef DISPLAY_MUX_EN
   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

   logic [REF_W-1:0]  ref_cnt;
   logic [DIGITS-1:0] sel_r, sel_next;
   logic [6:0]        seg_r, seg_next;

   // seg_mux is loaded with the digit that dig_sel selects in the same
   // cycle, so the two outputs always agree.
   always_comb begin
      sel_next = sel_r;
      seg_next = 7'b0000000;
      if (ref_cnt == REF_LAST) sel_next = (sel_r << 1) | (sel_r >> (DIGITS - 1));
      for (int i = 0; i < DIGITS; i++) begin
         if (sel_next[i]) seg_next = seg_decode(bcd_r[4*i +: 4]);
      end
   end

   // ---- stage: display scan ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_cnt <= '0;
         sel_r   <= DIGITS'(1);
         seg_r   <= 7'b0111111;
      end else begin
         ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + REF_W'(1);
         sel_r   <= sel_next;
         seg_r   <= seg_next;
      end
   end

   assign bus.seg_mux = seg_r;
   assign bus.dig_sel = sel_r;
`else
   always_comb begin
      bus.seg_all = '0;
      for (int i = 0; i < DIGITS; i++) begin
         bus.seg_all[7*i +: 7] = seg_decode(bcd_r[4*i +: 4]);
      end
   end
`endif

endmodule

// File: tb/tb_occupancy_monitor.sv
// ---------------------------------------------------------------------------
// tb_occupancy_monitor
// Directed bench for occupancy_monitor. dut_a uses the default parameters;
// dut_b uses CAPACITY=150 and REFRESH_DIV=4 for three-digit values and the
// optional scanned display (DISPLAY_MUX_EN).
// ---------------------------------------------------------------------------
module tb_occupancy_monitor;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   occupancy_monitor_if #(.CNT_W(8), .DIGITS(3)) bus_a ();
   occupancy_monitor_if #(.CNT_W(8), .DIGITS(3)) bus_b ();

   occupancy_monitor dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   occupancy_monitor #(
      .CAPACITY    (150),
      .REFRESH_DIV (4)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One sensor event: levels held 8 cycles, then released for 8 cycles.
   task automatic sense(input bit on_b, input bit en, input bit ex);
      if (on_b) begin
         bus_b.entry_det = en;
         bus_b.exit_det  = ex;
      end else begin
         bus_a.entry_det = en;
         bus_a.exit_det  = ex;
      end
      tick(8);
      if (on_b) begin
         bus_b.entry_det = 1'b0;
         bus_b.exit_det  = 1'b0;
      end else begin
         bus_a.entry_det = 1'b0;
         bus_a.exit_det  = 1'b0;
      end
      tick(8);
   endtask

   task automatic pulse_clear();
      bus_a.clear_flags = 1'b1;
      tick(1);
      bus_a.clear_flags = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus_a.count !== 8'd0) begin
         failures++; $display("FAIL reset_count got=%0d exp=0", bus_a.count);
      end
      checks++;
      if (bus_a.bcd !== 12'h000) begin
         failures++; $display("FAIL reset_bcd got=%h exp=000", bus_a.bcd);
      end
      checks++;
      if ({bus_a.alarm, bus_a.full, bus_a.overflow, bus_a.underflow} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000",
                  {bus_a.alarm, bus_a.full, bus_a.overflow, bus_a.underflow});
      end
`ifdef DISPLAY_MUX_EN
      checks++;
      if (bus_a.dig_sel !== 3'b001 || bus_a.seg_mux !== 7'b0111111) begin
         failures++;
         $display("FAIL reset_mux got=%b/%b exp=001/0111111", bus_a.dig_sel, bus_a.seg_mux);
      end
`else
      checks++;
      if (bus_a.seg_all !== {3{7'b0111111}}) begin
         failures++; $display("FAIL reset_seg got=%b exp=%b", bus_a.seg_all, {3{7'b0111111}});
      end
`endif
   endtask

   task automatic test_latency();
      bus_a.entry_det = 1'b1;
      tick(6);
      checks++;
      if (bus_a.count !== 8'd0) begin
         failures++; $display("FAIL latency_early got=%0d exp=0", bus_a.count);
      end
      tick(1);
      checks++;
      if (bus_a.count !== 8'd1) begin
         failures++; $display("FAIL latency_edge7 got=%0d exp=1", bus_a.count);
      end
      checks++;
      if (bus_a.bcd !== 12'h001) begin
         failures++; $display("FAIL latency_bcd got=%h exp=001", bus_a.bcd);
      end
`ifndef DISPLAY_MUX_EN
      checks++;
      if (bus_a.seg_all[6:0] !== 7'b0000110) begin
         failures++; $display("FAIL latency_seg got=%b exp=0000110", bus_a.seg_all[6:0]);
      end
`endif
      tick(3);
      bus_a.entry_det = 1'b0;
      tick(8);
      checks++;
      if (bus_a.count !== 8'd1) begin
         failures++; $display("FAIL latency_single got=%0d exp=1", bus_a.count);
      end
   endtask

   task automatic test_glitch();
      bus_a.entry_det = 1'b1;
      tick(3);
      bus_a.entry_det = 1'b0;
      tick(10);
      checks++;
      if (bus_a.count !== 8'd1) begin
         failures++; $display("FAIL glitch_count got=%0d exp=1", bus_a.count);
      end
      checks++;
      if ({bus_a.overflow, bus_a.underflow} !== 2'b00) begin
         failures++; $display("FAIL glitch_flags got=%b exp=00", {bus_a.overflow, bus_a.underflow});
      end
   endtask

   task automatic test_alarm();
      for (int i = 0; i < 78; i++) sense(1'b0, 1'b1, 1'b0);
      checks++;
      if (bus_a.count !== 8'd79 || bus_a.alarm !== 1'b0) begin
         failures++; $display("FAIL alarm_79 got=%0d/%b exp=79/0", bus_a.count, bus_a.alarm);
      end
      bus_a.entry_det = 1'b1;
      tick(7);
      checks++;
      if (bus_a.count !== 8'd80 || bus_a.alarm !== 1'b0) begin
         failures++; $display("FAIL alarm_80_now got=%0d/%b exp=80/0", bus_a.count, bus_a.alarm);
      end
      tick(1);
      checks++;
      if (bus_a.alarm !== 1'b1) begin
         failures++; $display("FAIL alarm_80_next got=%b exp=1", bus_a.alarm);
      end
      bus_a.entry_det = 1'b0;
      tick(8);
      for (int i = 0; i < 4; i++) sense(1'b0, 1'b0, 1'b1);
      checks++;
      if (bus_a.count !== 8'd76 || bus_a.alarm !== 1'b1) begin
         failures++; $display("FAIL alarm_76 got=%0d/%b exp=76/1", bus_a.count, bus_a.alarm);
      end
      sense(1'b0, 1'b0, 1'b1);
      checks++;
      if (bus_a.count !== 8'd75 || bus_a.alarm !== 1'b0) begin
         failures++; $display("FAIL alarm_75 got=%0d/%b exp=75/0", bus_a.count, bus_a.alarm);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 24; i++) sense(1'b0, 1'b1, 1'b0);
      checks++;
      if (bus_a.bcd !== 12'h099 || bus_a.full !== 1'b1) begin
         failures++; $display("FAIL full_99 got=%h/%b exp=099/1", bus_a.bcd, bus_a.full);
      end
      sense(1'b0, 1'b1, 1'b0);
      checks++;
      if (bus_a.count !== 8'd99 || bus_a.overflow !== 1'b1) begin
         failures++; $display("FAIL overflow_set got=%0d/%b exp=99/1", bus_a.count, bus_a.overflow);
      end
      pulse_clear();
      checks++;
      if (bus_a.overflow !== 1'b0) begin
         failures++; $display("FAIL overflow_clear got=%b exp=0", bus_a.overflow);
      end
      // clear_flags coincides with the rejected-entry event cycle
      bus_a.entry_det = 1'b1;
      tick(6);
      bus_a.clear_flags = 1'b1;
      tick(1);
      bus_a.clear_flags = 1'b0;
      checks++;
      if (bus_a.overflow !== 1'b1) begin
         failures++; $display("FAIL overflow_set_wins got=%b exp=1", bus_a.overflow);
      end
      tick(1);
      bus_a.entry_det = 1'b0;
      tick(8);
      pulse_clear();
      checks++;
      if (bus_a.overflow !== 1'b0 || bus_a.count !== 8'd99) begin
         failures++; $display("FAIL overflow_final got=%b/%0d exp=0/99", bus_a.overflow, bus_a.count);
      end
   endtask

   task automatic test_underflow_and_both();
      do_reset();
      sense(1'b0, 1'b0, 1'b1);
      checks++;
      if (bus_a.count !== 8'd0 || bus_a.underflow !== 1'b1) begin
         failures++; $display("FAIL underflow_set got=%0d/%b exp=0/1", bus_a.count, bus_a.underflow);
      end
      pulse_clear();
      for (int i = 0; i < 10; i++) sense(1'b0, 1'b1, 1'b0);
      checks++;
      if (bus_a.bcd !== 12'h010) begin
         failures++; $display("FAIL bcd_10 got=%h exp=010", bus_a.bcd);
      end
      sense(1'b0, 1'b1, 1'b1);
      checks++;
      if (bus_a.count !== 8'd10 || {bus_a.overflow, bus_a.underflow} !== 2'b00) begin
         failures++;
         $display("FAIL both_events got=%0d/%b exp=10/00", bus_a.count, {bus_a.overflow, bus_a.underflow});
      end
   endtask

   task automatic test_borrow();
      for (int i = 0; i < 100; i++) sense(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus_b.count !== 8'd100 || bus_b.bcd !== 12'h100) begin
         failures++; $display("FAIL carry_100 got=%0d/%h exp=100/100", bus_b.count, bus_b.bcd);
      end
      sense(1'b1, 1'b0, 1'b1);
      checks++;
      if (bus_b.count !== 8'd99 || bus_b.bcd !== 12'h099) begin
         failures++; $display("FAIL borrow_99 got=%0d/%h exp=99/099", bus_b.count, bus_b.bcd);
      end
   endtask

`ifdef DISPLAY_MUX_EN
   task automatic test_mux();
      int waited;
      for (int i = 0; i < 24; i++) sense(1'b1, 1'b1, 1'b0);
      waited = 0;
      while (bus_b.dig_sel !== 3'b001 && waited < 20) begin
         tick(1);
         waited++;
      end
      checks++;
      if (bus_b.dig_sel !== 3'b001) begin
         failures++; $display("FAIL mux_sync got=%b exp=001", bus_b.dig_sel);
      end
      checks++;
      if (bus_b.seg_mux !== 7'b1001111) begin
         failures++; $display("FAIL mux_d0 got=%b exp=1001111", bus_b.seg_mux);
      end
      tick(4);
      checks++;
      if (bus_b.dig_sel !== 3'b010 || bus_b.seg_mux !== 7'b1011011) begin
         failures++; $display("FAIL mux_d1 got=%b/%b exp=010/1011011", bus_b.dig_sel, bus_b.seg_mux);
      end
      tick(4);
      checks++;
      if (bus_b.dig_sel !== 3'b100 || bus_b.seg_mux !== 7'b0000110) begin
         failures++; $display("FAIL mux_d2 got=%b/%b exp=100/0000110", bus_b.dig_sel, bus_b.seg_mux);
      end
   endtask
`endif

   initial begin
      checks            = 0;
      failures          = 0;
      reset             = 1'b1;
      bus_a.entry_det   = 1'b0;
      bus_a.exit_det    = 1'b0;
      bus_a.clear_flags = 1'b0;
      bus_b.entry_det   = 1'b0;
      bus_b.exit_det    = 1'b0;
      bus_b.clear_flags = 1'b0;
      test_reset();
      test_latency();
      test_glitch();
      test_alarm();
      test_full();
      test_underflow_and_both();
      test_borrow();
`ifdef DISPLAY_MUX_EN
      test_mux();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/occupancy_monitor.md
Name: occupancy_monitor

Overview:
Bidirectional people counter for a monitored room. It takes separate entry and exit sensor inputs. The count saturates at a configurable capacity, and an alarm asserts at a threshold and releases with hysteresis. The block keeps an N-digit BCD copy of the count and drives 7-segment displays from it without any divider. It is the generalised successor of the single-direction counter, sitting between the door sensors and the front-panel display/alarm driver.

Parameters:
CNT_W, 8, width of the binary count (2..14)
CAPACITY, 99, maximum count; must be <= 10^DIGITS-1 and < 2^CNT_W
ALARM_HI, 80, count at or above which alarm asserts
HYST, 5, alarm releases when count <= ALARM_HI-HYST (HYST < ALARM_HI)
DIGITS, 3, number of BCD display digits
DEBOUNCE, 4, consecutive stable synchronised cycles required to accept a level change (>=1)
REFRESH_DIV, 1000, clk cycles per digit slot (only used with DISPLAY_MUX_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
entry_det  input  1  raw entry sensor level, asynchronous to clk
exit_det  input  1  raw exit sensor level, asynchronous to clk
clear_flags  input  1  synchronous pulse; clears sticky flags
count  output  CNT_W  current occupancy, binary
bcd  output  4*DIGITS  occupancy in BCD; digit 0 is in bits [3:0]
seg_all  output  7*DIGITS  parallel segments, {g..a} per digit, active-high, digit 0 in [6:0] (absent with DISPLAY_MUX_EN)
alarm  output  1  threshold alarm with hysteresis
full  output  1  count == CAPACITY
overflow  output  1  sticky: entry rejected at capacity
underflow  output  1  sticky: exit seen at zero

Behaviour:
- Reset (async): count=0, bcd=0, alarm=0, overflow=0, underflow=0, synchronisers and debouncers cleared to 0, seg_all shows "0" on every digit (7'b0111111), full=0.
- Input path per sensor:
  - 2-FF synchroniser feeds a debouncer.
  - The debounced level toggles once the synchronised value has differed from it for DEBOUNCE consecutive cycles; any agreement resets the run counter.
  - An event is a debounced 0->1 transition, one cycle wide.
- Update occurs on the edge after the event. Latency: a clean input step held high makes count change on the (DEBOUNCE+3)th rising edge after entry_det is first sampled high.
- Event resolution, same cycle, priority in order:
  - entry and exit both: no change, no flags.
  - entry only, count<CAPACITY: count+1.
  - entry only, count==CAPACITY: count unchanged, overflow<=1.
  - exit only, count>0: count-1.
  - exit only, count==0: count unchanged, underflow<=1.
- BCD is maintained incrementally in the same cycle as count, never computed by division:
  - Increment: digit 9->0 carries to the next digit.
  - Decrement: digit 0->9 borrows from the next digit.
  - Invariant: bcd always equals count in decimal.
- Alarm is registered and updates the cycle after count changes. It goes 0->1 when count >= ALARM_HI and 1->0 when count <= ALARM_HI-HYST; otherwise it holds.
- full is combinational from count.
- clear_flags clears overflow/underflow. If a flag-setting event occurs in the same cycle, the set wins.
- Segment decode is combinational from bcd: 0-9 standard, codes >9 blank (7'b0000000). Leading zeros are displayed.
- Reset mid-debounce discards any partially qualified event.

Optional Feature:
DISPLAY_MUX_EN
- Defined:
  - seg_all is replaced by seg_mux (output, 7) and dig_sel (output, DIGITS, one-hot).
  - A refresh counter advances dig_sel every REFRESH_DIV cycles, rotating digit 0 -> 1 -> ... -> DIGITS-1 -> 0.
  - seg_mux is registered and shows the selected digit.
  - Reset value: dig_sel=1, seg_mux=7'b0111111.
- Undefined: parallel seg_all only, with no refresh logic.

Test Plan:
- Reset, then entry_det high for 10 cycles (DEBOUNCE=4) -> count=1 on the 7th edge, bcd=12'h001, seg_all[6:0]=7'b0000110.
- entry_det glitch high for 3 cycles -> count stays 0, no flags.
- 80 clean entries -> alarm=1 one cycle after count=80; exits to 76 keep alarm=1; exit to 75 -> alarm=0.
- Entries to 99 -> bcd=12'h099, full=1; one more entry -> count=99, overflow=1; clear_flags -> overflow=0.
- Exit at count 0 -> underflow=1, count=0. Entry and exit events in the same cycle at count=10 -> count=10. Count 100->99 decrement -> bcd=12'h099 (CAPACITY=150).
- With DISPLAY_MUX_EN, REFRESH_DIV=4, count=123 -> dig_sel cycles 001, 010, 100 every 4 cycles with seg_mux = "3", "2", "1".
